nibble_serial_adder_ctrl: RTL and testbench
===========================================

// Module: nibble_serial_adder_ctrl
// PURPOSE
//  Upstream sequencer for the 4-bit ripple-carry binary adder. Accepts one WIDTH-bit
//  operand pair over a valid/ready handshake and feeds it one nibble per clock to the
//  external adder, LSB nibble first. The adder's carry-out is registered and fed back
//  as the next nibble's carry-in. The WIDTH-bit result is returned on a valid/ready
//  output port. The adder stays purely combinational outside this block.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of 4 and >= 8
//  NNIB   WIDTH/4 (localparam)  nibbles per operation
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair present
//  in_ready   out  1      block can accept an operand pair
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry-in for nibble 0
//  add_a      out  4      nibble of A to adder
//  add_b      out  4      nibble of B to adder
//  add_cin    out  1      carry to adder
//  add_sum    in   4      adder Sum
//  add_cout   in   1      adder Cout
//  out_valid  out  1      result held valid
//  out_ready  in   1      consumer accepts result
//  out_sum    out  WIDTH  result sum
//  out_cout   out  1      final carry-out
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE; in_ready=1; out_valid=0; out_sum=0; out_cout=0;
//    nibble index=0; carry reg=0; operand regs=0. Reset mid-operation discards the op.
//  - FSM IDLE -> RUN on in_valid&&in_ready. That edge latches in_a, in_b, in_cin into
//    carry reg, and sets index k=0.
//  - In RUN, the outputs are combinational from registers only:
//    add_a=a_reg[4k+:4], add_b=b_reg[4k+:4], add_cin=carry reg.
//  - Each RUN edge writes add_sum into sum_reg[4k+:4], writes add_cout into carry reg,
//    and sets k=k+1.
//  - RUN -> DONE on the edge with k==NNIB-1. out_sum=sum_reg and out_cout=carry reg.
//  - DONE: out_valid=1. out_sum and out_cout are stable until out_valid&&out_ready.
//    That edge: DONE -> IDLE, out_valid=0.
//  - Latency: acceptance at edge T; out_valid is high from edge T+NNIB+1 (WIDTH=16: 5).
//    With out_ready=1, the next accept is at edge T+NNIB+3 or later.
//  - in_ready=1 only in IDLE. No accept in the same cycle as the result handoff.
//  - in_valid and operand changes during RUN and DONE are ignored. The held operands
//    are unaffected.
//  - Outside RUN: add_a=0, add_b=0, add_cin=0.
//  - Sum arithmetic is modulo 2^WIDTH; overflow is seen only via out_cout.
//  - k is $clog2(NNIB) bits wide and never wraps past NNIB-1 while in RUN.
// CONFIGURATION
//  - SERIAL_ADD_OVF_EN defined: extra output port out_ovf (1 bit), registered with
//    out_sum. out_ovf = two's-complement overflow: carry into MSB XOR carry out of MSB.
//    For the top nibble this is computed as a[W-1]~^b[W-1] & (a[W-1]^sum[W-1]).
//    out_ovf resets to 0 and follows the same valid/hold rules as out_sum.
//  - SERIAL_ADD_OVF_EN undefined: out_ovf port and its logic are absent.
// TESTING  (WIDTH=16, real 4-bit ripple adder attached, out_ready=1 unless stated)
//  1. A=0x00FF, B=0x0001, cin=0 -> out_sum=0x0100, out_cout=0. out_valid 5 edges after
//     accept.
//  2. A=0xFFFF, B=0x0001, cin=0 -> out_sum=0x0000, out_cout=1. Carry ripples through
//     all 4 nibbles.
//  3. A=0x1234, B=0x4321, cin=1 -> out_sum=0x5556, out_cout=0. With OVF_EN:
//     A=0x7FFF + B=0x0001 -> out_ovf=1.
//  4. out_ready=0 for 10 cycles after result -> out_valid, out_sum, out_cout held and
//     in_ready=0. Release -> IDLE next edge.
//  5. New in_valid with A=0xAAAA during RUN -> ignored; the first op's result is
//     unchanged; the second op is accepted only after IDLE.
//  6. rst_n low at nibble 2 -> all outputs at reset values immediately.
//     Op A=0x0001+B=0x0001 after release -> 0x0002.

Source files
------------

// File: rtl/nibble_serial_adder_ctrl_if.sv
// Operand/result handshake bundle for nibble_serial_adder_ctrl.
// Defining SERIAL_ADD_OVF_EN adds the out_ovf signed-overflow flag.
interface nibble_serial_adder_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             out_ovf;
`endif

    // slave = the sequencer, master = the producer/consumer around it
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
`ifdef SERIAL_ADD_OVF_EN
        , output out_ovf
`endif
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
`ifdef SERIAL_ADD_OVF_EN
        , input out_ovf
`endif
    );
endinterface

// File: rtl/nibble_serial_adder_ctrl.sv
// Feeds a WIDTH-bit operand pair to an external 4-bit adder one nibble per clock.
// Optional feature macro: SERIAL_ADD_OVF_EN (adds registered out_ovf).
module nibble_serial_adder_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    nibble_serial_adder_ctrl_if.slave     bus,
    output logic [3:0]                    add_a,
    output logic [3:0]                    add_b,
    output logic                          add_cin,
    input  logic [3:0]                    add_sum,
    input  logic                          add_cout
);
    localparam int NNIB = WIDTH / 4;
    localparam int KW   = $clog2(NNIB);
    localparam logic [KW-1:0] K_LAST = KW'(NNIB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [KW-1:0]          k_q, k_d;
    logic [NNIB-1:0][3:0]   a_q, a_d;
    logic [NNIB-1:0][3:0]   b_q, b_d;
    logic [NNIB-1:0][3:0]   sum_q, sum_d;
    logic                   carry_q, carry_d;
    logic                   out_valid_q, out_valid_d;
    logic [WIDTH-1:0]       out_sum_q, out_sum_d;
    logic                   out_cout_q, out_cout_d;
`ifdef SERIAL_ADD_OVF_EN
    logic                   out_ovf_q, out_ovf_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            k_q         <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            out_ovf_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_cout_q  <= out_cout_d;
`ifdef SERIAL_ADD_OVF_EN
            out_ovf_q   <= out_ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = RUN;
            RUN:     if (k_q == K_LAST) state_d = DONE;
            DONE:    if (out_valid_q && bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // DONE spends its first cycle loading the result registers, so out_valid
    // rises one edge after the last nibble lands in sum_q.
    always_comb begin
        k_d         = k_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_cout_d  = out_cout_q;
`ifdef SERIAL_ADD_OVF_EN
        out_ovf_d   = out_ovf_q;
`endif
        add_a       = 4'h0;
        add_b       = 4'h0;
        add_cin     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.in_a;
                    b_d     = bus.in_b;
                    carry_d = bus.in_cin;
                    k_d     = '0;
                end
            end
            RUN: begin
                add_a      = a_q[k_q];
                add_b      = b_q[k_q];
                add_cin    = carry_q;
                sum_d[k_q] = add_sum;
                carry_d    = add_cout;
                if (k_q != K_LAST) k_d = k_q + 1'b1;
            end
            DONE: begin
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_sum_d   = sum_q;
                    out_cout_d  = carry_q;
`ifdef SERIAL_ADD_OVF_EN
                    out_ovf_d   = (a_q[NNIB-1][3] ~^ b_q[NNIB-1][3]) &
                                  (a_q[NNIB-1][3] ^ sum_q[NNIB-1][3]);
`endif
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_cout  = out_cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.out_ovf   = out_ovf_q;
`endif
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Directed self-checking bench for nibble_serial_adder_ctrl (WIDTH=16) with a
// behavioural 4-bit ripple adder attached; out_ovf checks need SERIAL_ADD_OVF_EN.
module tb_nibble_serial_adder_ctrl;
    localparam int WIDTH = 16;

    logic       clk;
    logic       rst_n;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    nibble_serial_adder_ctrl_if #(.WIDTH(WIDTH)) bus ();

    nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus.slave),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Presents one operand pair at a negedge and returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin);
        int waited = 0;
        while (!bus.in_ready && waited < 20) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        checkOutput("accept_ready", {31'b0, bus.in_ready}, 32'd1);
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_cin   = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic waitResult(output int cycles);
        cycles = -1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.out_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_cin    = 1'b0;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        checkOutput("rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        checkOutput("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("rst_out_sum",   {16'b0, bus.out_sum},   32'd0);
        checkOutput("rst_out_cout",  {31'b0, bus.out_cout},  32'd0);
        checkOutput("rst_add_a",     {28'b0, add_a},         32'd0);
        checkOutput("rst_add_cin",   {31'b0, add_cin},       32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] test 1: 0x00FF + 0x0001");
        applyStimulus(16'h00FF, 16'h0001, 1'b0);
        checkOutput("t1_in_ready_run", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("t1_add_a_nib0",   {28'b0, add_a},        32'hF);
        checkOutput("t1_add_b_nib0",   {28'b0, add_b},        32'h1);
        checkOutput("t1_add_cin_nib0", {31'b0, add_cin},      32'd0);
        waitResult(lat);
        checkOutput("t1_latency",  lat,                    32'd5);
        checkOutput("t1_out_sum",  {16'b0, bus.out_sum},   32'h0100);
        checkOutput("t1_out_cout", {31'b0, bus.out_cout},  32'd0);
`ifdef SERIAL_ADD_OVF_EN
        checkOutput("t1_out_ovf",  {31'b0, bus.out_ovf},   32'd0);
`endif
        @(posedge clk);
        @(negedge clk);
        checkOutput("t1_valid_drop", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("t1_idle_ready", {31'b0, bus.in_ready},  32'd1);

        $display("[TB] test 2: 0xFFFF + 0x0001");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0);
        checkOutput("t2_add_cin_nib0", {31'b0, add_cin}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t2_add_cin_nib1", {31'b0, add_cin}, 32'd1);
        checkOutput("t2_add_a_nib1",   {28'b0, add_a},   32'hF);
        checkOutput("t2_add_b_nib1",   {28'b0, add_b},   32'h0);
        waitResult(lat);
        checkOutput("t2_latency",  lat,                   32'd4);
        checkOutput("t2_out_sum",  {16'b0, bus.out_sum},  32'h0000);
        checkOutput("t2_out_cout", {31'b0, bus.out_cout}, 32'd1);
        @(negedge clk);

        $display("[TB] test 3: 0x1234 + 0x4321 + 1");
        applyStimulus(16'h1234, 16'h4321, 1'b1);
        waitResult(lat);
        checkOutput("t3_latency",  lat,                   32'd5);
        checkOutput("t3_out_sum",  {16'b0, bus.out_sum},  32'h5556);
        checkOutput("t3_out_cout", {31'b0, bus.out_cout}, 32'd0);
        @(negedge clk);
`ifdef SERIAL_ADD_OVF_EN
        applyStimulus(16'h7FFF, 16'h0001, 1'b0);
        waitResult(lat);
        checkOutput("t3_ovf_sum",  {16'b0, bus.out_sum},  32'h8000);
        checkOutput("t3_ovf_cout", {31'b0, bus.out_cout}, 32'd0);
        checkOutput("t3_ovf_flag", {31'b0, bus.out_ovf},  32'd1);
        @(negedge clk);
`endif

        $display("[TB] test 4: consumer stall");
        bus.out_ready = 1'b0;
        applyStimulus(16'h0F0F, 16'h00F1, 1'b0);
        waitResult(lat);
        checkOutput("t4_latency", lat, 32'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            checkOutput("t4_hold_valid", {31'b0, bus.out_valid}, 32'd1);
            checkOutput("t4_hold_sum",   {16'b0, bus.out_sum},   32'h1000);
            checkOutput("t4_hold_cout",  {31'b0, bus.out_cout},  32'd0);
            checkOutput("t4_hold_ready", {31'b0, bus.in_ready},  32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("t4_release_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("t4_release_ready", {31'b0, bus.in_ready},  32'd1);

        $display("[TB] test 5: second request during RUN");
        applyStimulus(16'h1111, 16'h2222, 1'b0);
        bus.in_a     = 16'hAAAA;
        bus.in_b     = 16'h5555;
        bus.in_cin   = 1'b0;
        bus.in_valid = 1'b1;
        checkOutput("t5_busy_ready", {31'b0, bus.in_ready}, 32'd0);
        waitResult(lat);
        checkOutput("t5_first_latency", lat,                   32'd5);
        checkOutput("t5_first_sum",     {16'b0, bus.out_sum},  32'h3333);
        checkOutput("t5_first_cout",    {31'b0, bus.out_cout}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t5_handoff_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("t5_handoff_ready", {31'b0, bus.in_ready},  32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        checkOutput("t5_second_ready", {31'b0, bus.in_ready}, 32'd0);
        checkOutput("t5_second_add_a", {28'b0, add_a},        32'hA);
        checkOutput("t5_second_add_b", {28'b0, add_b},        32'h5);
        waitResult(lat);
        checkOutput("t5_second_latency", lat,                   32'd5);
        checkOutput("t5_second_sum",     {16'b0, bus.out_sum},  32'hFFFF);
        checkOutput("t5_second_cout",    {31'b0, bus.out_cout}, 32'd0);
        @(negedge clk);

        $display("[TB] test 6: reset at nibble 2");
        applyStimulus(16'h1234, 16'h1111, 1'b0);
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        checkOutput("t6_add_a_nib2", {28'b0, add_a}, 32'h2);
        rst_n = 1'b0;
        #1;
        checkOutput("t6_rst_in_ready",  {31'b0, bus.in_ready},  32'd1);
        checkOutput("t6_rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
        checkOutput("t6_rst_out_sum",   {16'b0, bus.out_sum},   32'h0000);
        checkOutput("t6_rst_out_cout",  {31'b0, bus.out_cout},  32'd0);
        checkOutput("t6_rst_add_a",     {28'b0, add_a},         32'd0);
        checkOutput("t6_rst_add_b",     {28'b0, add_b},         32'd0);
        checkOutput("t6_rst_add_cin",   {31'b0, add_cin},       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(16'h0001, 16'h0001, 1'b0);
        waitResult(lat);
        checkOutput("t6_post_latency", lat,                   32'd5);
        checkOutput("t6_post_sum",     {16'b0, bus.out_sum},  32'h0002);
        checkOutput("t6_post_cout",    {31'b0, bus.out_cout}, 32'd0);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
